// File: rtl/rd_hs_pkg.sv
// Shared definitions for the rd/ws/ds read handshake, used by both
// the initiator (read controller) and the target-side responder.
package rd_hs_pkg;

   // Responder states
   typedef enum logic [1:0] {
      R_IDLE  = 2'd0,
      R_WAIT  = 2'd1,
      R_RETRY = 2'd2,
      R_DATA  = 2'd3
   } rsp_state_t;

   // Initiator (read controller) states
   typedef enum logic [1:0] {
      I_IDLE = 2'd0,
      I_READ = 2'd1,
      I_DLY  = 2'd2,
      I_DONE = 2'd3
   } init_state_t;

   localparam int RD_AW_DEF = 4;
   localparam int RD_DW_DEF = 8;
   localparam int RD_CW_DEF = 4;

   // Wait-state decode: ready only in R_WAIT once the wait count is spent
   function automatic logic rsp_ws(input rsp_state_t st, input logic cnt_zero);
      return !((st == R_WAIT) && cnt_zero);
   endfunction

endpackage

// File: rtl/rd_regfile.sv
// Flop-based register file: one synchronous write port, one
// combinational read port, contents cleared by the asynchronous reset.
module rd_regfile #(
   parameter int AW = 4,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [AW-1:0] i_raddr,
   output logic [DW-1:0] o_rdata
);

   localparam int DEPTH = 1 << AW;

   logic [DW-1:0] r_mem [DEPTH];

   // Storage: clear on reset, otherwise write on we
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= {DW{1'b0}};
         end
      end else if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Read returns the pre-edge contents, so a same-edge write is not seen
   assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/rd_wait_responder.sv
// Target-side responder for the rd/ws/ds read handshake. Captures the
// request, inserts the configured number of wait states by holding ws
// high, then presents register-file data for the initiator's DONE cycle.
module rd_wait_responder
   import rd_hs_pkg::*;
#(
   parameter int AW = RD_AW_DEF,
   parameter int DW = RD_DW_DEF,
   parameter int CW = RD_CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_rd,
   input  logic          i_ds,
   input  logic [AW-1:0] i_addr,
   input  logic [CW-1:0] i_wait_cfg,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   output logic          o_ws,
   output logic [DW-1:0] o_rdata,
   output logic          o_busy,
   output logic          o_err
);

   rsp_state_t    r_state;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_addr_q;
   logic [DW-1:0] r_rdata;
   logic          r_err;
   logic [DW-1:0] w_mem_rdata;
   logic          w_cnt_zero;

   rd_regfile #(
      .AW (AW),
      .DW (DW)
   ) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (i_we),
      .i_waddr (i_waddr),
      .i_wdata (i_wdata),
      .i_raddr (r_addr_q),
      .o_rdata (w_mem_rdata)
   );

   assign w_cnt_zero = (r_cnt == {CW{1'b0}});

   // Responder FSM with wait counter, captured address, read data and error pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= R_IDLE;
         r_cnt    <= {CW{1'b0}};
         r_addr_q <= {AW{1'b0}};
         r_rdata  <= {DW{1'b0}};
         r_err    <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            R_IDLE: begin
               if (i_rd) begin
                  r_state  <= R_WAIT;
                  r_addr_q <= i_addr;
                  r_cnt    <= i_wait_cfg;
               end
            end
            R_WAIT: begin
               // Dropping rd here means the initiator gave up in its DLY cycle
               if (!i_rd) begin
                  r_state <= R_IDLE;
                  r_err   <= 1'b1;
               end else if (!w_cnt_zero) begin
                  r_state <= R_RETRY;
                  r_cnt   <= r_cnt - CW'(1);
               end else begin
                  r_state <= R_DATA;
                  r_rdata <= w_mem_rdata;
               end
            end
            R_RETRY: begin
               if (i_rd) begin
                  r_state <= R_WAIT;
               end else begin
                  r_state <= R_IDLE;
                  r_err   <= 1'b1;
               end
            end
            R_DATA: begin
               if (i_ds) begin
                  r_state <= R_IDLE;
               end else if (i_rd) begin
                  // Skipped DONE: flag it, but serve the new request anyway
                  r_err    <= 1'b1;
                  r_state  <= R_WAIT;
                  r_addr_q <= i_addr;
                  r_cnt    <= i_wait_cfg;
               end
            end
            default: begin
               r_state <= R_IDLE;
            end
         endcase
      end
   end

   // Outputs are pure decodes of registered state; no input reaches them
   assign o_ws    = rsp_ws(r_state, w_cnt_zero);
   assign o_busy  = (r_state != R_IDLE);
   assign o_rdata = r_rdata;
   assign o_err   = r_err;

endmodule

// File: tb/tb_rd_wait_responder.sv
// Self-checking bench for rd_wait_responder: directed scenarios followed by
// randomized reads, checked against a transaction-level model of the
// handshake timing (ws pattern from N, data = memory at the load cycle).
module tb_rd_wait_responder;

   localparam int AW = 4;
   localparam int DW = 8;
   localparam int CW = 4;

   logic          clk;
   logic          rst_n;
   logic          rd;
   logic          ds;
   logic          we;
   logic [AW-1:0] addr;
   logic [AW-1:0] waddr;
   logic [CW-1:0] wait_cfg;
   logic [DW-1:0] wdata;
   logic          ws;
   logic          busy;
   logic          err;
   logic [DW-1:0] rdata;

   logic [DW-1:0] mem_m [16];
   logic [DW-1:0] last_rd;
   int            n_checks = 0;
   int            n_err    = 0;

   rd_wait_responder #(
      .AW (AW),
      .DW (DW),
      .CW (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_rd       (rd),
      .i_ds       (ds),
      .i_addr     (addr),
      .i_wait_cfg (wait_cfg),
      .i_we       (we),
      .i_waddr    (waddr),
      .i_wdata    (wdata),
      .o_ws       (ws),
      .o_rdata    (rdata),
      .o_busy     (busy),
      .o_err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: inputs held across the edge, then model absorbs any write
   task automatic tick();
      @(posedge clk);
      #1;
      if (we) mem_m[waddr] = wdata;
      we = 1'b0;
   endtask

   task automatic wr(input int a, input int d);
      rd = 1'b0; ds = 1'b0;
      we = 1'b1; waddr = AW'(a); wdata = DW'(d);
      tick();
   endtask

   task automatic start(input int a, input int n);
      rd = 1'b1; ds = 1'b0;
      addr = AW'(a); wait_cfg = CW'(n);
      tick();
   endtask

   task automatic garble(input bit rnd);
      if (rnd) begin
         addr     = AW'($urandom);
         wait_cfg = CW'($urandom);
         if ($urandom_range(0, 2) == 0) begin
            we = 1'b1; waddr = AW'($urandom); wdata = DW'($urandom);
         end
      end
   endtask

   // Entered in cycle t+1; leaves in t+2+2N (initiator DONE) with data checked
   task automatic run_to_data(input int a, input int n, input bit rnd,
                              input bit coll, input int cd, input bit first_err);
      logic [DW-1:0] exp_d;
      exp_d = '0;
      for (int k = 0; k <= n; k++) begin
         chk("ws_dly", ws, (k < n) ? 1 : 0);
         chk("busy_dly", busy, 1);
         chk("err_dly", err, (k == 0) ? first_err : 1'b0);
         chk("rdata_hold", rdata, last_rd);
         rd = 1'b1; ds = 1'b0;
         garble(rnd);
         if (k == n && coll) begin
            we = 1'b1; waddr = AW'(a); wdata = DW'(cd);
         end
         if (k == n) exp_d = mem_m[a];
         tick();
         if (k < n) begin
            chk("ws_retry", ws, 1);
            chk("busy_retry", busy, 1);
            chk("err_retry", err, 0);
            rd = 1'b1;
            garble(rnd);
            tick();
         end
      end
      chk("rdata", rdata, exp_d);
      chk("ws_data", ws, 1);
      chk("busy_data", busy, 1);
      chk("err_data", err, 0);
      last_rd = exp_d;
   endtask

   task automatic finish_ds();
      rd = 1'b0; ds = 1'b1;
      tick();
      ds = 1'b0;
      chk("busy_end", busy, 0);
      chk("ws_end", ws, 1);
      chk("err_end", err, 0);
      chk("rdata_keep", rdata, last_rd);
   endtask

   task automatic do_read(input int a, input int n, input bit rnd);
      start(a, n);
      run_to_data(a, n, rnd, 1'b0, 0, 1'b0);
      finish_ds();
   endtask

   task automatic err_gone();
      chk("err_pulse", err, 1);
      chk("busy_abort", busy, 0);
      chk("ws_abort", ws, 1);
      chk("rdata_abort", rdata, last_rd);
      tick();
      chk("err_once", err, 0);
      chk("busy_idle", busy, 0);
   endtask

   task automatic abort_retry(input int a, input int n);
      start(a, n);
      chk("ws_t1", ws, 1);
      rd = 1'b1;
      tick();
      chk("ws_retry_ab", ws, 1);
      rd = 1'b0;
      tick();
      err_gone();
   endtask

   task automatic abort_wait(input int a, input int n);
      start(a, n);
      chk("ws_t1w", ws, (n != 0) ? 1 : 0);
      rd = 1'b0;
      tick();
      err_gone();
   endtask

   initial begin
      rst_n = 1'b1; rd = 1'b0; ds = 1'b0; we = 1'b0;
      addr = '0; waddr = '0; wait_cfg = '0; wdata = '0;
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      last_rd = '0;

      // Reset values
      #3 rst_n = 1'b0;
      #1;
      chk("rst_ws", ws, 1);
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_err", err, 0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      // Reset in the middle of a wait-stretched read
      wr(2, 8'h55);
      do_read(2, 1, 1'b0);
      start(2, 3);
      rd = 1'b1;
      tick();
      chk("pre_rst_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("mrst_ws", ws, 1);
      chk("mrst_busy", busy, 0);
      chk("mrst_rdata", rdata, 0);
      chk("mrst_err", err, 0);
      for (int i = 0; i < 16; i++) mem_m[i] = '0;
      last_rd = '0;
      rd = 1'b0;
      tick();
      chk("mrst_ws2", ws, 1);
      chk("mrst_busy2", busy, 0);
      chk("mrst_err2", err, 0);
      rst_n = 1'b1;
      tick();
      for (int a = 0; a < 16; a++) do_read(a, 0, 1'b0);

      // Zero wait and multi-wait reads
      wr(3, 8'hA5);
      do_read(3, 0, 1'b0);
      wr(7, 8'h3C);
      do_read(7, 3, 1'b0);

      // Config and address changes after capture are ignored
      wr(9, 8'h77);
      start(9, 2);
      wait_cfg = 4'd0; addr = 4'd3;
      run_to_data(9, 2, 1'b0, 1'b0, 0, 1'b0);
      finish_ds();

      // Same-edge write and data load
      wr(5, 8'h11);
      start(5, 0);
      run_to_data(5, 0, 1'b0, 1'b1, 8'h22, 1'b0);
      finish_ds();
      do_read(5, 0, 1'b0);

      // Aborts, each followed by a clean read
      abort_retry(7, 2);
      do_read(7, 1, 1'b0);
      abort_wait(3, 0);
      do_read(3, 2, 1'b0);

      // New request in place of DONE
      start(7, 1);
      run_to_data(7, 1, 1'b0, 1'b0, 0, 1'b0);
      rd = 1'b1; ds = 1'b0; addr = 4'd9; wait_cfg = 4'd2;
      tick();
      run_to_data(9, 2, 1'b0, 1'b0, 0, 1'b1);
      finish_ds();

      // Randomized traffic with background writes
      for (int t = 0; t < 40; t++) begin
         int a, n, kind;
         a    = $urandom_range(0, 15);
         n    = $urandom_range(0, 6);
         kind = $urandom_range(0, 9);
         if (kind == 0 && n > 0) abort_retry(a, n);
         else if (kind == 1) abort_wait(a, n);
         else if (kind == 2) begin
            wr($urandom_range(0, 15), $urandom_range(0, 255));
            start(a, n);
            run_to_data(a, n, 1'b1, 1'b1, $urandom_range(0, 255), 1'b0);
            finish_ds();
         end else begin
            if (kind > 6) wr(a, $urandom_range(0, 255));
            do_read(a, n, 1'b1);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
